// File: rtl/snes_pkg.sv
// ============================================================================
// Module : snes_pkg
// Types and the fixed-priority picker shared by the SNES source arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package snes_pkg;

  typedef enum logic [1:0] {
    SRC_KBD  = 2'b00,
    SRC_BTN  = 2'b01,
    SRC_IR   = 2'b10,
    SRC_NONE = 2'b11
  } src_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  localparam int SNES_DATA_W = 16;

  // act bit order: [0]=keyboard, [1]=button, [2]=IR; keyboard wins
  function automatic src_e prio_pick(input logic [2:0] act);
    if (act[0])      return SRC_KBD;
    else if (act[1]) return SRC_BTN;
    else if (act[2]) return SRC_IR;
    else             return SRC_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snes_hold_timer.sv
// ============================================================================
// Module : snes_hold_timer
// Reloadable idle counter; saturates at zero and flags expiry when empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module snes_hold_timer #(
  parameter int HOLD_CYCLES = 600000
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic expired
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (reload) begin
      count <= CNT_W'(HOLD_CYCLES);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

`default_nettype wire

// File: rtl/snes_source_arbiter.sv
// ============================================================================
// Module : snes_source_arbiter
// Chooses which input source drives the SNES data mux; ownership moves only
// on a console latch pulse. Optional macro SNES_ARB_PREEMPT_EN enables
// higher-priority preemption at a latch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module snes_source_arbiter
  import snes_pkg::*;
#(
  parameter int DATA_W      = SNES_DATA_W,
  parameter int HOLD_CYCLES = 600000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] keyboard_data,
  input  logic [DATA_W-1:0] button_data,
  input  logic [DATA_W-1:0] ir_data,
  input  logic              snes_latch,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              owner_change
);

  arb_state_e state;
  src_e       sel_q;
  src_e       sel_d;
  logic [2:0] act;
  src_e       best;
  logic       owner_act;
  logic       preempt;
  logic       handover;
  logic       reload;
  logic       expired;

  always_comb begin
    act       = {|ir_data, |button_data, |keyboard_data};
    best      = prio_pick(act);
    owner_act = 1'b0;
    if (state == ARB_OWNED) begin
      case (sel_q)
        SRC_KBD: owner_act = act[0];
        SRC_BTN: owner_act = act[1];
        SRC_IR:  owner_act = act[2];
        default: owner_act = 1'b0;
      endcase
    end
`ifdef SNES_ARB_PREEMPT_EN
    // encoding order equals priority order, so a smaller code outranks the owner
    preempt = snes_latch && (state == ARB_OWNED) && (best != SRC_NONE) && (best < sel_q);
`else
    preempt = 1'b0;
`endif
    handover = snes_latch && (state == ARB_OWNED) && (preempt || expired);
    reload   = owner_act
             || (snes_latch && (state == ARB_IDLE) && (best != SRC_NONE))
             || (handover && (best != SRC_NONE));
  end

  snes_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .reload (reload),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      sel_q        <= SRC_NONE;
      sel_d        <= SRC_NONE;
      busy         <= 1'b0;
      owner_change <= 1'b0;
    end else begin
      sel_d        <= sel_q;
      owner_change <= (sel_q != sel_d);
      case (state)
        ARB_IDLE: begin
          if (snes_latch && (best != SRC_NONE)) begin
            sel_q <= best;
            busy  <= 1'b1;
            state <= ARB_OWNED;
          end
        end
        ARB_OWNED: begin
          if (handover) begin
            if (best != SRC_NONE) begin
              sel_q <= best;
            end else begin
              sel_q <= SRC_NONE;
              busy  <= 1'b0;
              state <= ARB_IDLE;
            end
          end
        end
        default: begin
          state <= ARB_IDLE;
          sel_q <= SRC_NONE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_snes_source_arbiter.sv
// ============================================================================
// Module : tb_snes_source_arbiter
// Scoreboard bench for snes_source_arbiter with an abstract ownership model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_snes_source_arbiter;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] kb = '0, bt = '0, ir = '0;
  logic        latch = 1'b0;
  logic [1:0]  sel;
  logic        busy;
  logic        owner_change;

  always #5 clk = ~clk;

  snes_source_arbiter #(
    .DATA_W(16),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keyboard_data(kb),
    .button_data  (bt),
    .ir_data      (ir),
    .snes_latch   (latch),
    .sel          (sel),
    .busy         (busy),
    .owner_change (owner_change)
  );

  typedef struct {
    int sel;
    int busy;
    int oc;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  // model: owner 3 means nobody; timer counts idle clocks left
  int m_owner = 3;
  int m_timer = 0;
  int m_last  = 3;
  int m_oc    = 0;

  task automatic cyc();
    int   best;
    int   act[3];
    int   nxt_owner;
    int   nxt_timer;
    exp_t e;
    act[0] = (kb != 0);
    act[1] = (bt != 0);
    act[2] = (ir != 0);
    best = 3;
    for (int i = 2; i >= 0; i--) if (act[i] != 0) best = i;
    if (reset) begin
      m_owner = 3; m_timer = 0; m_last = 3; m_oc = 0;
    end else begin
      nxt_owner = m_owner;
      nxt_timer = m_timer;
      if (m_owner == 3) begin
        if (latch && best != 3) begin
          nxt_owner = best;
          nxt_timer = HOLD;
        end
      end else begin
        nxt_timer = act[m_owner] ? HOLD : ((m_timer > 0) ? m_timer - 1 : 0);
        if (latch) begin
`ifdef SNES_ARB_PREEMPT_EN
          if (best < m_owner) begin
            nxt_owner = best;
            nxt_timer = HOLD;
          end else
`endif
          if (m_timer == 0) begin
            nxt_owner = best;
            if (best != 3) nxt_timer = HOLD;
          end
        end
      end
      m_oc    = (m_owner != m_last);
      m_last  = m_owner;
      m_owner = nxt_owner;
      m_timer = nxt_timer;
    end
    e.sel  = m_owner;
    e.busy = (m_owner != 3);
    e.oc   = m_oc;
    e.idx  = cyc_no;
    exp_q.push_back(e);
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_latch();
    latch = 1'b1;
    cyc();
    latch = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    kb = '0; bt = '0; ir = '0;
    run(2);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (int'(sel) != e.sel || int'(busy) != e.busy || int'(owner_change) != e.oc) begin
        n_fail++;
        $display("FAIL cycle%0d sel/busy/owner_change: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 e.idx, sel, busy, owner_change, e.sel, e.busy, e.oc);
      end
    end
  end

  initial begin
    // 1: reset dominates a latch with active inputs
    reset = 1'b1; kb = 16'h0001; bt = 16'h0002; latch = 1'b1;
    run(2);
    latch = 1'b0; kb = '0; bt = '0;
    reset = 1'b0;
    run(2);

    // 2: button beats IR, then release after idling
    bt = 16'h0010; ir = 16'h0001;
    pulse_latch();
    bt = '0; ir = '0;
    run(9);
    pulse_latch();
    run(3);

    // 3: keyboard owner stays despite IR activity
    do_reset();
    kb = 16'h0004;
    pulse_latch();
    ir = 16'h0800;
    for (int i = 0; i < 40; i++) begin
      kb = (i % 5 == 0) ? 16'h0004 : 16'h0000;
      latch = (i % 10 == 9);
      cyc();
    end
    latch = 1'b0;

    // 4: expired IR owner hands directly to keyboard
    do_reset();
    ir = 16'h0001;
    pulse_latch();
    ir = '0; kb = 16'h0100;
    run(10);
    pulse_latch();
    run(3);

    // 5: activity entirely between latches is not granted
    do_reset();
    kb = 16'h0001;
    run(3);
    kb = '0;
    pulse_latch();
    run(2);

    // 6: keyboard activity while IR owner is active
    do_reset();
    ir = 16'h0002;
    pulse_latch();
    kb = 16'h0001;
    run(2);
    pulse_latch();
    run(3);

    // randomized traffic with varying density
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int dens;
      dens = 1 + ph;
      for (int i = 0; i < 300; i++) begin
        kb = ($urandom_range(0, dens) == 0) ? 16'($urandom) : 16'h0;
        bt = ($urandom_range(0, dens) == 0) ? 16'($urandom) : 16'h0;
        ir = ($urandom_range(0, dens) == 0) ? 16'($urandom) : 16'h0;
        latch = ($urandom_range(0, 5) == 0);
        reset = ($urandom_range(0, 249) == 0);
        cyc();
      end
    end
    reset = 1'b0; latch = 1'b0;
    run(2);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
